cq_request_parser: RTL
======================

Name: cq_request_parser

Overview:
Registered, back-pressured successor to the combinational CQ descriptor decoder. Sits between the PCIe hard-IP completer-request AXI-Stream (m_axis_cq) and the BAR register file / CC completer. Accepts multi-beat memory writes of up to MAX_WR_DW dwords and filters by BAR. Rejects unsupported or malformed requests. Presents one registered request descriptor at a time on a valid/ready interface.

Parameters:
DATA_WIDTH, 256, CQ AXI-Stream width in bits; legal values 128, 256, 512.
BAR0_SIZE, 16, byte-address width of decoded BAR window.
MAX_WR_DW, 16, maximum write payload in dwords; must be at least 2.
BAR_EN_MASK, 6'b000001, bit n set means BAR n is accepted.

Ports:
clk  in  1  user clock from PCIe IP
rst_n  in  1  asynchronous active-low reset
m_axis_cq_tdata  in  DATA_WIDTH  CQ data; descriptor in [127:0] of first beat
m_axis_cq_tvalid  in  1  CQ beat valid
m_axis_cq_tuser  in  85  CQ sideband; first_be = [3:0], last_be = [11:8]
m_axis_cq_tkeep  in  DATA_WIDTH/32  dword enables
m_axis_cq_tlast  in  1  last beat of TLP
m_axis_cq_tready  out  1  beat accepted when tvalid && tready
cq_valid  out  1  descriptor valid; held until cq_ready
cq_ready  in  1  downstream accepts descriptor
cq_is_write  out  1  memory write (req_type 4'b0001)
cq_is_read  out  1  memory read (req_type 4'b0000)
cq_reg_addr  out  BAR0_SIZE  dword-aligned byte address, low 2 bits zero
cq_lower_addr  out  7  {addr[6:2],2'b00} for CC
cq_dword_count  out  11  descriptor dword count
cq_first_be  out  4  first dword byte enables
cq_last_be  out  4  last dword byte enables
cq_wr_data  out  MAX_WR_DW*32  write payload; dword i at [32i+31:32i]; unused dwords zero
cq_bar_id  out  3  target BAR
cq_requester_id  out  16  requester ID
cq_tag  out  8  tag
cq_tc  out  3  traffic class
cq_drop_cnt  out  16  saturating count of discarded requests

Behaviour:
- Reset: all outputs 0, payload buffer zeroed, state IDLE; m_axis_cq_tready is 0 while rst_n is low and 1 in IDLE after reset.
- Field extraction matches the CQ descriptor layout:
  - addr [BAR0_SIZE-1:2]
  - dword_count [74:64]
  - req_type [78:75]
  - requester_id [95:80]
  - tag [103:96]
  - bar_id [114:112]
  - tc [123:121]
- First-beat payload starts at bit 128 (dword 4). Later beats carry DATA_WIDTH/32 payload dwords from bit 0.
- States:
  - IDLE: tready=1. On an accepted first beat, latch descriptor fields and classify:
    - Reject if req_type is not 0000/0001, BAR_EN_MASK[bar_id]==0, dword_count==0, or write with dword_count>MAX_WR_DW.
    - Rejected and tlast=1: increment cq_drop_cnt, stay IDLE.
    - Rejected and tlast=0: go to DROP.
    - Accepted read: go to HOLD. Descriptor beat without tlast: DROP the remainder, count the drop.
    - Accepted write: store first-beat payload dwords; dw_cnt += dwords stored.
      - tlast=1 and dw_cnt>=dword_count: go to HOLD.
      - tlast=1 and short: malformed; drop, count.
      - tlast=0: go to COLLECT.
  - COLLECT: tready=1. Each accepted beat stores min(remaining, DATA_WIDTH/32) dwords at index dw_cnt. Excess dwords are ignored.
    - tlast with dw_cnt>=dword_count: HOLD.
    - tlast short: malformed; clear buffer, count drop, IDLE.
  - DROP: tready=1; discard beats until accepted tlast, then count and go IDLE.
  - HOLD: tready=0, cq_valid=1, all descriptor outputs stable. On cq_ready: cq_valid falls the next cycle, buffer cleared, IDLE.
- Latency: cq_valid rises on the clock edge after the accepted beat that completes the request.
- cq_is_read/cq_is_write are qualified by cq_valid; both are 0 when cq_valid=0.
- tkeep is not used for counting; dword_count is authoritative.
- cq_drop_cnt saturates at 16'hFFFF, never wraps, and is cleared only by reset.
- Assertion of rst_n low mid-packet: immediate return to IDLE, outputs cleared. The remaining beats of that packet after reset are treated as a new first beat; this is upstream's responsibility.
- Throughput: at most one request per 2 cycles (HOLD plus IDLE).

Test Plan:
- 1-DW read: bar 0, addr 0x0010, tag 0x2A, tlast on beat 0 -> cq_valid next cycle, is_read=1, reg_addr=0x0010, lower_addr=0x10, dword_count=1, tag=0x2A; tready=0 until cq_ready.
- 2-DW write, DATA_WIDTH=256, payload 0x11111111/0x22222222 in beat 0 -> wr_data[63:0]=0x22222222_11111111, upper dwords 0, first_be/last_be latched.
- 12-DW write over 2 beats (4 + 8 dwords) -> HOLD after beat 1; wr_data holds dwords 0..11 in order.
- cq_ready held low 5 cycles in HOLD while tvalid=1 -> tready stays 0, outputs stable, no beat lost; the next request is accepted after release.
- Rejections: I/O request (req_type 0010), BAR 2 with default mask, write of dword_count=17, short write with tlast after 4 of 8 DW -> no cq_valid, drop_cnt=4, the following valid read is processed normally.
- Reset mid-COLLECT -> all outputs 0, drop_cnt=0, tready=1 one cycle after rst_n deasserts.

Source files
------------

// File: rtl/cq_request_parser.sv
// Completer-request parser: takes CQ TLPs from the PCIe hard IP, filters them
// by type/BAR/length, gathers write payload and holds one registered request
// descriptor on a valid/ready interface until downstream takes it.
module cq_request_parser #(
  parameter int         DATA_WIDTH  = 256,
  parameter int         BAR0_SIZE   = 16,
  parameter int         MAX_WR_DW   = 16,
  parameter logic [5:0] BAR_EN_MASK = 6'b000001
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     m_axis_cq_tdata,
  input  logic                      m_axis_cq_tvalid,
  input  logic [84:0]               m_axis_cq_tuser,
  input  logic [DATA_WIDTH/32-1:0]  m_axis_cq_tkeep,
  input  logic                      m_axis_cq_tlast,
  output logic                      m_axis_cq_tready,
  output logic                      cq_valid,
  input  logic                      cq_ready,
  output logic                      cq_is_write,
  output logic                      cq_is_read,
  output logic [BAR0_SIZE-1:0]      cq_reg_addr,
  output logic [6:0]                cq_lower_addr,
  output logic [10:0]               cq_dword_count,
  output logic [3:0]                cq_first_be,
  output logic [3:0]                cq_last_be,
  output logic [MAX_WR_DW*32-1:0]   cq_wr_data,
  output logic [2:0]                cq_bar_id,
  output logic [15:0]               cq_requester_id,
  output logic [7:0]                cq_tag,
  output logic [2:0]                cq_tc,
  output logic [15:0]               cq_drop_cnt
);

  localparam int BEAT_DW  = DATA_WIDTH / 32;
  localparam int FIRST_DW = BEAT_DW - 4;
  localparam int CW       = 12;
  localparam logic [7:0] BAR_MASK8 = {2'b00, BAR_EN_MASK};

  typedef enum logic [1:0] {IDLE, COLLECT, DROP, HOLD} state_t;

  state_t state, state_nxt;

  logic                     beat_fire;
  logic [3:0]               desc_type;
  logic                     desc_rd;
  logic                     desc_wr;
  logic [10:0]              desc_dw;
  logic [2:0]               desc_bar;
  logic                     desc_reject;
  logic [DATA_WIDTH-1:0]    pay_bits;
  logic [CW-1:0]            eff_dw;
  logic [CW-1:0]            base_cnt;
  logic [CW-1:0]            avail;
  logic [CW-1:0]            remaining;
  logic [CW-1:0]            take;
  logic [CW-1:0]            next_cnt;
  logic                     enough;
  logic [CW-1:0]            dw_cnt;
  logic                     rd_q;
  logic                     wr_q;
  logic [MAX_WR_DW-1:0][31:0] wr_buf;
  logic                     latch_desc;
  logic                     store_en;
  logic                     buf_clr;
  logic                     drop_evt;
  logic                     unused_sigs;

  assign unused_sigs = &{1'b0, m_axis_cq_tkeep, m_axis_cq_tuser[84:12], m_axis_cq_tuser[7:4]};

  assign m_axis_cq_tready = rst_n && (state != HOLD);
  assign beat_fire        = m_axis_cq_tvalid && m_axis_cq_tready;
  assign cq_valid         = (state == HOLD);
  assign cq_is_read       = cq_valid && rd_q;
  assign cq_is_write      = cq_valid && wr_q;
  assign cq_wr_data       = wr_buf;

  // Decode and classify the descriptor sitting in the low 128 bits of the beat
  always_comb begin
    desc_type   = m_axis_cq_tdata[78:75];
    desc_dw     = m_axis_cq_tdata[74:64];
    desc_bar    = m_axis_cq_tdata[114:112];
    desc_rd     = (desc_type == 4'b0000);
    desc_wr     = (desc_type == 4'b0001);
    desc_reject = !(desc_rd || desc_wr) || !BAR_MASK8[desc_bar] || (desc_dw == 11'd0) ||
                  (desc_wr && (desc_dw > 11'(MAX_WR_DW)));
  end

  // Work out how many payload dwords this beat contributes and whether the request is complete
  always_comb begin
    pay_bits  = (state == IDLE) ? (m_axis_cq_tdata >> 128) : m_axis_cq_tdata;
    eff_dw    = (state == IDLE) ? {1'b0, desc_dw} : {1'b0, cq_dword_count};
    base_cnt  = (state == IDLE) ? '0 : dw_cnt;
    avail     = (state == IDLE) ? CW'(FIRST_DW) : CW'(BEAT_DW);
    remaining = eff_dw - base_cnt;
    take      = (remaining < avail) ? remaining : avail;
    next_cnt  = base_cnt + take;
    enough    = (next_cnt >= eff_dw);
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    state_nxt  = state;
    latch_desc = 1'b0;
    store_en   = 1'b0;
    buf_clr    = 1'b0;
    drop_evt   = 1'b0;
    case (state)
      IDLE: begin
        if (beat_fire) begin
          latch_desc = 1'b1;
          if (desc_reject) begin
            if (m_axis_cq_tlast) drop_evt  = 1'b1;
            else                 state_nxt = DROP;
          end else if (desc_rd) begin
            state_nxt = m_axis_cq_tlast ? HOLD : DROP;
          end else if (m_axis_cq_tlast) begin
            if (enough) begin
              store_en  = 1'b1;
              state_nxt = HOLD;
            end else begin
              drop_evt = 1'b1;
            end
          end else begin
            store_en  = 1'b1;
            state_nxt = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (beat_fire) begin
          if (!m_axis_cq_tlast) begin
            store_en = 1'b1;
          end else if (enough) begin
            store_en  = 1'b1;
            state_nxt = HOLD;
          end else begin
            buf_clr   = 1'b1;
            drop_evt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      DROP: begin
        if (beat_fire && m_axis_cq_tlast) begin
          drop_evt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (cq_ready) begin
          buf_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Descriptor fields are captured from the first beat of every TLP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_reg_addr     <= '0;
      cq_lower_addr   <= '0;
      cq_dword_count  <= '0;
      cq_first_be     <= '0;
      cq_last_be      <= '0;
      cq_bar_id       <= '0;
      cq_requester_id <= '0;
      cq_tag          <= '0;
      cq_tc           <= '0;
      rd_q            <= 1'b0;
      wr_q            <= 1'b0;
    end else if (latch_desc) begin
      cq_reg_addr     <= {m_axis_cq_tdata[BAR0_SIZE-1:2], 2'b00};
      cq_lower_addr   <= {m_axis_cq_tdata[6:2], 2'b00};
      cq_dword_count  <= desc_dw;
      cq_first_be     <= m_axis_cq_tuser[3:0];
      cq_last_be      <= m_axis_cq_tuser[11:8];
      cq_bar_id       <= desc_bar;
      cq_requester_id <= m_axis_cq_tdata[95:80];
      cq_tag          <= m_axis_cq_tdata[103:96];
      cq_tc           <= m_axis_cq_tdata[123:121];
      rd_q            <= desc_rd;
      wr_q            <= desc_wr;
    end
  end

  // Payload buffer: dword k of this beat lands in slot dw_cnt+k; excess dwords are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_buf <= '0;
      dw_cnt <= '0;
    end else if (buf_clr) begin
      wr_buf <= '0;
      dw_cnt <= '0;
    end else if (store_en) begin
      dw_cnt <= next_cnt;
      for (int j = 0; j < MAX_WR_DW; j++) begin
        for (int k = 0; k < BEAT_DW; k++) begin
          if ((CW'(k) < take) && ((base_cnt + CW'(k)) == CW'(j)))
            wr_buf[j] <= pay_bits[32*k +: 32];
        end
      end
    end
  end

  // Saturating count of discarded requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cq_drop_cnt <= '0;
    else if (drop_evt && cq_drop_cnt != 16'hFFFF) cq_drop_cnt <= cq_drop_cnt + 16'd1;
  end

endmodule
